// File: rtl/cache_wb_buffer.sv
// Write-back buffer: queues dirty-line evictions and uncached stores from the data cache
// and drains each entry, oldest first, as one AXI3 write burst. Also answers read-path hazard probes.
module cache_wb_buffer #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    input  logic [31:0]  chk_addr,
    output logic         chk_hit,
    output logic         wb_empty,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic         awvalid,
    input  logic         awready,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic         bvalid,
    output logic         bready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Handshakes: a transfer happens on the rising edge where valid & ready are both high;
    // valid and its payload never change while valid is high and ready is low.
    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_e;

    state_e         state_q, state_d;
    logic [1:0]     beat_q, beat_d;
    logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;

    logic [2:0]     type_q  [DEPTH];
    logic [2:0]     type_d  [DEPTH];
    logic [31:0]    addr_q  [DEPTH];
    logic [31:0]    addr_d  [DEPTH];
    logic [3:0]     wstrb_q [DEPTH];
    logic [3:0]     wstrb_d [DEPTH];
    logic [127:0]   data_q  [DEPTH];
    logic [127:0]   data_d  [DEPTH];

    logic           push, pop;
    logic           head_is_line, head_last;
    logic [127:0]   head_data;
    logic           unused_chk;

    assign unused_chk = ^chk_addr[3:0];

    assign wr_rdy   = (count_q != CW'(DEPTH));
    assign wb_empty = (count_q == '0) && (state_q == S_IDLE);
    assign push     = wr_req && wr_rdy;
    assign pop      = (state_q == S_B) && bvalid;

    // Queue bookkeeping; a push never targets the slot being popped.
    always_comb begin
        type_d  = type_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        data_d  = data_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            type_d[tail_q]  = wr_type;
            addr_d[tail_q]  = wr_addr;
            wstrb_d[tail_q] = wr_wstrb;
            data_d[tail_q]  = wr_data;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    assign head_is_line = type_q[head_q][2];
    assign head_data    = data_q[head_q];
    assign head_last    = head_is_line ? (beat_q == 2'd3) : 1'b1;

    assign awaddr = addr_q[head_q];
    assign awlen  = head_is_line ? 8'd3 : 8'd0;
    assign awsize = head_is_line ? 3'd2 : {1'b0, type_q[head_q][1:0]};
    assign wdata  = head_is_line ? head_data[{beat_q, 5'd0} +: 32] : head_data[31:0];
    assign wstrb  = head_is_line ? 4'hf : wstrb_q[head_q];
    assign wlast  = (state_q == S_W) && head_last;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (state_q)
            S_IDLE: if (count_q != '0) state_d = S_AW;
            S_AW: begin
                awvalid = 1'b1;
                if (awready) state_d = S_W;
            end
            S_W: begin
                wvalid = 1'b1;
                if (wready) begin
                    if (head_last) state_d = S_B;
                    else           beat_d  = beat_q + 1'b1;
                end
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_d = S_IDLE;
                    beat_d  = 2'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The head stays visible to the probe until its write response is taken.
    always_comb begin
        chk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            chk_hit = chk_hit | (valid_q[i] & (addr_q[i][31:4] == chk_addr[31:4]));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            beat_q  <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                type_q[i] <= 3'd0;
                addr_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
        end
    end

    // Payload storage needs no reset: it is only read behind a valid entry.
    always_ff @(posedge clk) begin
        wstrb_q <= wstrb_d;
        data_q  <= data_d;
    end

endmodule
